// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Issues the PC stream to the icache under
// a credit limit, buffers returned instructions in a small FIFO for decode, and
// flushes both the request stream and the buffer on a redirect.
module fetch_ctrl #(
  parameter int              ADDR      = 32,
  parameter int              INST      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR-1:0] RESET_VEC = '0,
  parameter int              PC_INC    = 4
) (
  input  logic            clk,
  input  logic            reset,
  // icache link
  output logic            fetch_e_,
  output logic [ADDR-1:0] fetch_pc,
  output logic            flush_,
  input  logic            ic_e_,
  input  logic [ADDR-1:0] ic_pc,
  input  logic [INST-1:0] ic_inst,
  input  logic            ic_stall_,
  // decode link
  output logic            inst_e_,
  output logic [ADDR-1:0] inst_pc,
  output logic [INST-1:0] inst,
  input  logic            dec_stall,
  // redirect
  input  logic            redirect_e_,
  input  logic [ADDR-1:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;

  // Buffer storage carries no reset; validity is tracked by cnt_q alone.
  logic [ADDR-1:0] mem_pc_q   [DEPTH];
  logic [INST-1:0] mem_inst_q [DEPTH];

  logic          redir;
  logic          run;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          req;
  logic          resp;
  logic          full;
  logic          push;
  logic          vld;
  logic          pop;

  // Qualifying conditions for request, response acceptance and decode handoff.
  // A redirect overrides everything in its cycle: no request, response dropped.
  always_comb begin
    redir      = !redirect_e_;
    run        = (state_q == S_RUN);
    credit_sum = {1'b0, outst_q} + {1'b0, cnt_q};
    credit_ok  = (credit_sum < (CW+1)'(DEPTH));
    req        = run && !redir && ic_stall_ && credit_ok;
    resp       = run && !redir && !ic_e_;
    full       = (cnt_q == CW'(DEPTH));
    push       = resp && !full;
    vld        = (cnt_q != '0) && (state_q != S_FLUSH);
    pop        = vld && !dec_stall && !redir;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  // FSM next state: any redirect (in any state) lands in FLUSH; BOOT and
  // FLUSH each last one cycle.
  always_comb begin
    state_d = state_q;
    if (redir) begin
      state_d = S_FLUSH;
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_FLUSH: state_d = S_RUN;
        default: state_d = S_BOOT;
      endcase
    end
  end

  // FSM outputs; data outputs read as zero whenever not valid.
  always_comb begin
    fetch_e_ = !req;
    fetch_pc = req ? pc_q : '0;
    flush_   = (state_q != S_FLUSH);
    inst_e_  = !vld;
    inst_pc  = vld ? mem_pc_q[rd_q]   : '0;
    inst     = vld ? mem_inst_q[rd_q] : '0;
  end

  // Next-state for PC, credit counter and FIFO pointers.
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (redir) begin
      pc_d    = redirect_pc;
      outst_d = '0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      if (req) pc_d = pc_q + ADDR'(PC_INC);
      // A response retires a credit even if it had to be dropped.
      case ({req, resp && (outst_q != '0)})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC;
      outst_q <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Instruction buffer write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_q]   <= ic_pc;
      mem_inst_q[wr_q] <= ic_inst;
    end
  end

  // A response into a full buffer means the icache broke the credit protocol.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(resp && full));

endmodule
